alu_ea_sequencer: RTL and testbench

//  Effective-address sequencer for the 6502 core. Time-shares the ALU operand muxes and the ALU.

---
 rtl/alu_ea_sequencer_pkg.sv | 47 ++++
 rtl/alu_ea_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_ea_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ea_sequencer_pkg.sv
// Shared encodings for the effective-address sequencer and the ALU input mux:
// mux select codes, addressing-mode encodings and sequencer states.
package alu_ea_sequencer_pkg;

    localparam logic [2:0] MUX_A    = 3'd1;
    localparam logic [2:0] MUX_X    = 3'd2;
    localparam logic [2:0] MUX_Y    = 3'd3;
    localparam logic [2:0] MUX_DATA = 3'd4;
    localparam logic [2:0] MUX_SP   = 3'd5;
    localparam logic [2:0] MUX_ONE  = 3'd6;

    typedef enum logic [2:0] {
        MODE_ZPX  = 3'd0,
        MODE_ZPY  = 3'd1,
        MODE_ABSX = 3'd2,
        MODE_ABSY = 3'd3,
        MODE_INDX = 3'd4,
        MODE_INDY = 3'd5,
        MODE_BAD6 = 3'd6,
        MODE_BAD7 = 3'd7
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_LO = 3'd1,
        S_FETCH_HI = 3'd2,
        S_PTR_LO   = 3'd3,
        S_PTR_HI   = 3'd4,
        S_FIXUP    = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    function automatic logic mode_legal(input logic [2:0] m);
        return (m <= 3'd5);
    endfunction

    // Modes 0, 2 and 4 index with X; the remaining legal modes index with Y.
    function automatic logic [2:0] idx_code(input logic [2:0] m);
        logic [2:0] code;
        case (m)
            3'd0, 3'd2, 3'd4: code = MUX_X;
            default:          code = MUX_Y;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ea_sequencer.sv
// Effective-address sequencer: walks the operand/pointer fetches of the indexed
// and indirect modes, steering the shared ALU and assembling a 16-bit EA.
module alu_ea_sequencer
    import alu_ea_sequencer_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int EA_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             rmw,
    input  logic [EA_W-1:0]  pc_in,
    output logic             fetch_req,
    output logic [EA_W-1:0]  fetch_addr,
    input  logic             fetch_ack,
    input  logic [7:0]       data_in,
    output logic [IDX_W-1:0] mux_a_sel,
    output logic [IDX_W-1:0] mux_b_sel,
    output logic             alu_add,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic [EA_W-1:0]  ea,
    output logic             page_cross,
    output logic             busy,
    output logic             done,
    output logic             bad_mode
);

    state_e     state;
    mode_e      mode_r;
    logic       rmw_r;
    logic [7:0] ptr;
    logic       c;

    // Sequence context: latched mode/rmw, zero-page pointer and low-byte carry.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            mode_r <= mode_e'(mode);
            rmw_r  <= rmw;
        end
        if (state == S_FETCH_LO && fetch_ack) begin
            ptr <= alu_out;
            c   <= alu_carry;
        end
        if (state == S_PTR_LO && fetch_ack && mode_r == MODE_INDY) begin
            c <= alu_carry;
        end
    end

    // Every output is registered; each transition loads the values the next state presents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ea         <= '0;
            page_cross <= 1'b0;
            fetch_req  <= 1'b0;
            fetch_addr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bad_mode   <= 1'b0;
            mux_a_sel  <= MUX_DATA;
            mux_b_sel  <= MUX_DATA;
            alu_add    <= 1'b0;
        end else begin
            done     <= 1'b0;
            bad_mode <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (mode_legal(mode)) begin
                            state      <= S_FETCH_LO;
                            fetch_req  <= 1'b1;
                            fetch_addr <= pc_in;
                            mux_a_sel  <= MUX_DATA;
                            if (mode_e'(mode) == MODE_INDY) begin
                                mux_b_sel <= MUX_DATA;
                                alu_add   <= 1'b0;
                            end else begin
                                mux_b_sel <= idx_code(mode);
                                alu_add   <= 1'b1;
                            end
                        end else begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            bad_mode   <= 1'b1;
                            ea         <= '0;
                            page_cross <= 1'b0;
                        end
                    end
                end

                S_FETCH_LO: begin
                    if (fetch_ack) begin
                        case (mode_r)
                            MODE_ZPX, MODE_ZPY: begin
                                // Zero-page indexing wraps inside page 0; the carry is dropped.
                                ea         <= {8'h00, alu_out};
                                state      <= S_DONE;
                                done       <= 1'b1;
                                page_cross <= 1'b0;
                                fetch_req  <= 1'b0;
                                mux_a_sel  <= MUX_DATA;
                                mux_b_sel  <= MUX_DATA;
                                alu_add    <= 1'b0;
                            end
                            MODE_ABSX, MODE_ABSY: begin
                                ea[7:0]    <= alu_out;
                                state      <= S_FETCH_HI;
                                fetch_addr <= pc_in + 16'd1;
                                mux_a_sel  <= MUX_DATA;
                                mux_b_sel  <= MUX_DATA;
                                alu_add    <= 1'b0;
                            end
                            default: begin
                                state      <= S_PTR_LO;
                                fetch_addr <= {8'h00, alu_out};
                                mux_a_sel  <= MUX_DATA;
                                if (mode_r == MODE_INDY) begin
                                    mux_b_sel <= MUX_Y;
                                    alu_add   <= 1'b1;
                                end else begin
                                    mux_b_sel <= MUX_DATA;
                                    alu_add   <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                S_FETCH_HI: begin
                    if (fetch_ack) begin
                        ea[EA_W-1:8] <= alu_out;
                        fetch_req    <= 1'b0;
                        if (c || rmw_r) begin
                            state <= S_FIXUP;
                        end else begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            page_cross <= c;
                        end
                    end
                end

                S_PTR_LO: begin
                    if (fetch_ack) begin
                        ea[7:0]    <= alu_out;
                        state      <= S_PTR_HI;
                        // Pointer high byte stays in page 0: FF wraps to 00.
                        fetch_addr <= {8'h00, ptr + 8'd1};
                        mux_a_sel  <= MUX_DATA;
                        mux_b_sel  <= MUX_DATA;
                        alu_add    <= 1'b0;
                    end
                end

                S_PTR_HI: begin
                    if (fetch_ack) begin
                        ea[EA_W-1:8] <= data_in;
                        fetch_req    <= 1'b0;
                        if (mode_r == MODE_INDY && (c || rmw_r)) begin
                            state <= S_FIXUP;
                        end else begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            page_cross <= (mode_r == MODE_INDY) && c;
                        end
                    end
                end

                S_FIXUP: begin
                    ea[EA_W-1:8] <= ea[EA_W-1:8] + {7'd0, c};
                    state        <= S_DONE;
                    done         <= 1'b1;
                    page_cross   <= c;
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    fetch_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ea_sequencer.sv
// Bench for alu_ea_sequencer: behavioural ALU and memory, directed spec cases,
// then randomized sequences checked against an addressing-mode reference model.
module tb_alu_ea_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  mode;
    logic        rmw;
    logic [15:0] pc_in;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [7:0]  data_in;
    logic [2:0]  mux_a_sel;
    logic [2:0]  mux_b_sel;
    logic        alu_add;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic [15:0] ea;
    logic        page_cross;
    logic        busy;
    logic        done;
    logic        bad_mode;

    alu_ea_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .rmw(rmw), .pc_in(pc_in),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .data_in(data_in), .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel),
        .alu_add(alu_add), .alu_out(alu_out), .alu_carry(alu_carry), .ea(ea),
        .page_cross(page_cross), .busy(busy), .done(done), .bad_mode(bad_mode)
    );

    always #5 clk = ~clk;

    logic [7:0]  reg_a, reg_x, reg_y, reg_sp;
    logic [7:0]  mem [0:65535];
    logic [15:0] seen_addrs[$];
    logic [15:0] exp_addrs[$];
    int          waits_q[$];
    int          max_wait;
    int          total_wait;
    int          checks;
    int          passed;

    function automatic logic [7:0] sel_val(input logic [2:0] code, input logic [7:0] a,
                                           input logic [7:0] x, input logic [7:0] y,
                                           input logic [7:0] d, input logic [7:0] sp);
        case (code)
            3'd1: return a;
            3'd2: return x;
            3'd3: return y;
            3'd4: return d;
            3'd5: return sp;
            3'd6: return 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, sel_val(mux_a_sel, reg_a, reg_x, reg_y, data_in, reg_sp)};
        if (alu_add)
            alu_sum = alu_sum + {1'b0, sel_val(mux_b_sel, reg_a, reg_x, reg_y, data_in, reg_sp)};
    end
    assign alu_out   = alu_sum[7:0];
    assign alu_carry = alu_sum[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Bus responder: per-fetch wait states, address must hold until the ack.
    initial begin : responder
        bit          in_wait;
        int          cur_wait;
        logic [15:0] held;
        in_wait   = 0;
        cur_wait  = 0;
        held      = '0;
        fetch_ack = 1'b0;
        data_in   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || !fetch_req) begin
                fetch_ack = 1'b0;
                data_in   = 8'($urandom);
                in_wait   = 0;
            end else begin
                if (!in_wait) begin
                    held     = fetch_addr;
                    cur_wait = (waits_q.size() > 0) ? waits_q.pop_front() : $urandom_range(0, max_wait);
                    in_wait  = 1;
                end else begin
                    check("addr_stable", fetch_addr, held);
                end
                if (cur_wait == 0) begin
                    fetch_ack = 1'b1;
                    data_in   = mem[fetch_addr];
                    seen_addrs.push_back(fetch_addr);
                    in_wait   = 0;
                end else begin
                    fetch_ack = 1'b0;
                    data_in   = 8'($urandom);
                    cur_wait--;
                    total_wait++;
                end
            end
        end
    end

    // Reference: effective address from the 6502 addressing-mode definitions.
    task automatic model(input logic [2:0] m, input logic [15:0] pc, input bit r,
                         output logic [15:0] e, output bit pcx, output bit bad, output int lat);
        logic [7:0] idx, op, p, p1;
        int         base;
        exp_addrs.delete();
        idx = (m == 3'd0 || m == 3'd2 || m == 3'd4) ? reg_x : reg_y;
        op  = mem[pc];
        e   = '0;
        pcx = 0;
        bad = 0;
        case (m)
            3'd0, 3'd1: begin
                e   = 16'((int'(op) + int'(idx)) % 256);
                lat = 2;
                exp_addrs.push_back(pc);
            end
            3'd2, 3'd3: begin
                base = int'({mem[pc + 16'd1], op});
                e    = 16'((base + int'(idx)) % 65536);
                pcx  = (int'(op) + int'(idx)) > 255;
                lat  = (pcx || r) ? 4 : 3;
                exp_addrs.push_back(pc);
                exp_addrs.push_back(pc + 16'd1);
            end
            3'd4, 3'd5: begin
                p    = (m == 3'd4) ? 8'((int'(op) + int'(reg_x)) % 256) : op;
                p1   = 8'((int'(p) + 1) % 256);
                base = int'({mem[16'(p1)], mem[16'(p)]});
                if (m == 3'd4) begin
                    e   = 16'(base);
                    lat = 4;
                end else begin
                    e   = 16'((base + int'(reg_y)) % 65536);
                    pcx = (int'(mem[16'(p)]) + int'(reg_y)) > 255;
                    lat = (pcx || r) ? 5 : 4;
                end
                exp_addrs.push_back(pc);
                exp_addrs.push_back(16'(p));
                exp_addrs.push_back(16'(p1));
            end
            default: begin
                bad = 1;
                lat = 1;
            end
        endcase
    endtask

    task automatic run_seq(input logic [2:0] m, input logic [15:0] pc, input bit r,
                           input bit poke, input string tag);
        logic [15:0] e;
        bit          pcx, bad, got;
        int          lat, cyc;
        model(m, pc, r, e, pcx, bad, lat);
        @(negedge clk);
        seen_addrs.delete();
        total_wait = 0;
        start = 1'b1;
        mode  = m;
        pc_in = pc;
        rmw   = r;
        cyc   = 0;
        got   = 0;
        while (cyc < 200 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            start = poke && (cyc == 2);
            mode  = start ? 3'd6 : m;
            if (done) got = 1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_cycle"}, cyc, lat + total_wait);
        check({tag, "_ea"}, ea, e);
        check({tag, "_page_cross"}, page_cross, pcx);
        check({tag, "_bad_mode"}, bad_mode, bad);
        check({tag, "_busy_in_done"}, busy, 1'b1);
        check({tag, "_nfetch"}, seen_addrs.size(), exp_addrs.size());
        for (int i = 0; i < exp_addrs.size(); i++)
            check({tag, "_addr"}, (i < seen_addrs.size()) ? seen_addrs[i] : 16'hxxxx, exp_addrs[i]);
        start = poke;
        mode  = 3'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = m;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_req"}, fetch_req, 1'b0);
        check({tag, "_idle_mux"}, {mux_a_sel, mux_b_sel, alu_add}, {3'd4, 3'd4, 1'b0});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ea"}, ea, 16'h0000);
        check({tag, "_ctrl"}, {page_cross, fetch_req, busy, done, bad_mode}, 5'b0);
        check({tag, "_mux"}, {mux_a_sel, mux_b_sel, alu_add}, {3'd4, 3'd4, 1'b0});
    endtask

    initial begin
        checks = 0;
        passed = 0;
        max_wait = 0;
        total_wait = 0;
        reg_a = 8'h5A; reg_x = 8'h00; reg_y = 8'h00; reg_sp = 8'hFD;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b1; start = 1'b0; mode = 3'd0; rmw = 1'b0; pc_in = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        reg_x = 8'h10; mem[16'h0200] = 8'hF8;
        run_seq(3'd0, 16'h0200, 1'b0, 1'b0, "zpx");

        reg_y = 8'h20; mem[16'h0300] = 8'hF0; mem[16'h0301] = 8'h12;
        run_seq(3'd3, 16'h0300, 1'b0, 1'b0, "absy_cross");
        reg_y = 8'h01;
        run_seq(3'd3, 16'h0300, 1'b0, 1'b0, "absy_nocross");
        run_seq(3'd3, 16'h0300, 1'b1, 1'b0, "absy_rmw");

        reg_x = 8'h01; mem[16'h0400] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        run_seq(3'd4, 16'h0400, 1'b0, 1'b0, "indx_wrap");

        reg_y = 8'h01; mem[16'h0500] = 8'h40; mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'hFF;
        run_seq(3'd5, 16'h0500, 1'b0, 1'b0, "indy_hiwrap");
        mem[16'h0500] = 8'hFF; mem[16'h00FF] = 8'h80; mem[16'h0000] = 8'h21;
        run_seq(3'd5, 16'h0500, 1'b0, 1'b0, "indy_ptrwrap");

        reg_x = 8'h03; mem[16'h0600] = 8'h10; mem[16'h0601] = 8'h44;
        waits_q.push_back(0);
        waits_q.push_back(3);
        run_seq(3'd2, 16'h0600, 1'b0, 1'b1, "absx_wait");

        // Reset while PTR_LO holds its fetch request.
        reg_x = 8'h05; mem[16'h0700] = 8'h20;
        @(negedge clk);
        start = 1'b1; mode = 3'd4; pc_in = 16'h0700; rmw = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check("ptr_lo_req", fetch_req, 1'b1);
        check("ptr_lo_addr", fetch_addr, 16'h0025);
        rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        run_seq(3'd6, 16'h0800, 1'b0, 1'b0, "bad6");
        run_seq(3'd7, 16'h0800, 1'b1, 1'b1, "bad7");

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  rm;
            logic [15:0] rpc;
            rm  = 3'($urandom_range(0, 7));
            rpc = 16'($urandom);
            reg_x = 8'($urandom);
            reg_y = 8'($urandom);
            max_wait = $urandom_range(0, 2);
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            mem[rpc] = 8'($urandom);
            mem[rpc + 16'd1] = 8'($urandom);
            run_seq(rm, rpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
